// File: rtl/laser500_pkg.sv
// Shared definitions for the laser500 SPI memory transfer helpers:
// command codes, upload FSM states and the underrun fill byte.
package laser500_pkg;

    localparam logic [7:0] CMD_LEN_DEF    = 8'h56;
    localparam logic [7:0] CMD_UPLOAD_DEF = 8'h57;
    localparam logic [7:0] UNDERRUN_FILL  = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        LEN,
        UPL,
        DRAIN
    } upl_state_t;

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchronisers for the SPI slave inputs plus single-clock
// sck edge pulses derived from the synchronised clock.
module spi_in_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic sck,
    input  logic ss,
    input  logic sdi,
    output logic ss_s,
    output logic sdi_s,
    output logic sck_rise,
    output logic sck_fall
);

    logic [1:0] sck_ff;
    logic [1:0] ss_ff;
    logic [1:0] sdi_ff;
    logic       sck_prev;

    // ss resets low so a select already asserted at reset release never
    // looks like a fresh falling edge; only a high-to-low transition counts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_ff   <= '0;
            ss_ff    <= '0;
            sdi_ff   <= '0;
            sck_prev <= 1'b0;
        end else begin
            sck_ff   <= {sck_ff[0], sck};
            ss_ff    <= {ss_ff[0], ss};
            sdi_ff   <= {sdi_ff[0], sdi};
            sck_prev <= sck_ff[1];
        end
    end

    assign ss_s     = ss_ff[1];
    assign sdi_s    = sdi_ff[1];
    assign sck_rise = sck_ff[1] & ~sck_prev;
    assign sck_fall = ~sck_ff[1] & sck_prev;

endmodule

// File: rtl/data_upload.sv
// SPI slave transmitter streaming memory contents (or the upload length)
// to the io controller, with a one-byte read prefetch buffer.
module data_upload
    import laser500_pkg::*;
#(
    parameter int              ADDR_W     = 25,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [7:0]      CMD_LEN    = CMD_LEN_DEF,
    parameter logic [7:0]      CMD_UPLOAD = CMD_UPLOAD_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sck,
    input  logic              ss,
    input  logic              sdi,
    output logic              sdo,
    output logic              sdo_oe,
    input  logic [ADDR_W-1:0] upload_len,
    output logic              uploading,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    input  logic              rd_ack,
    output logic [ADDR_W-1:0] bytes_sent
);

    logic ss_s, sdi_s, sck_rise, sck_fall;

    spi_in_sync u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .sck      (sck),
        .ss       (ss),
        .sdi      (sdi),
        .ss_s     (ss_s),
        .sdi_s    (sdi_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall)
    );

    upl_state_t        state_q, state_d;
    logic              ss_prev, ss_fall, ss_rise;
    logic [2:0]        bit_cnt;
    logic [1:0]        len_cnt;
    logic [6:0]        rx;
    logic [7:0]        rx_byte, tx, nxt, load_byte;
    logic              nxt_valid, pending, req_busy, ack_ok;
    logic              byte_done, mem_load, issue_first, issue_next, issue;
    logic [ADDR_W-1:0] ld_idx, read_idx;

    assign ss_fall   = ss_prev & ~ss_s;
    assign ss_rise   = ~ss_prev & ss_s;
    assign rx_byte   = {rx, sdi_s};
    assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state_q != IDLE) && !ss_rise;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ss_fall) state_d = CMD;
            CMD: begin
                if (byte_done) begin
                    if (rx_byte == CMD_LEN)         state_d = LEN;
                    else if (rx_byte == CMD_UPLOAD) state_d = UPL;
                    else                            state_d = DRAIN;
                end
            end
            default: ;
        endcase
        if (ss_rise) state_d = IDLE;
    end

    // Byte to place in the TX shifter when the current byte completes.
    always_comb begin
        load_byte = 8'h00;
        mem_load  = 1'b0;
        if (byte_done) begin
            case (state_d)
                LEN: begin
                    if (state_q == CMD)        load_byte = upload_len[23:16];
                    else if (len_cnt == 2'd1)  load_byte = upload_len[15:8];
                    else if (len_cnt == 2'd2)  load_byte = upload_len[7:0];
                end
                UPL: begin
                    if (ld_idx < upload_len) begin
                        mem_load  = 1'b1;
                        load_byte = nxt_valid ? nxt : UNDERRUN_FILL;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_busy    = pending && !rd_ack;
    assign issue_first = (state_q == IDLE) && ss_fall && (upload_len != '0) && !req_busy;
    assign issue_next  = mem_load && ((ld_idx + ADDR_W'(1)) < upload_len) && !req_busy;
    assign issue       = issue_first || issue_next;
    assign read_idx    = issue_first ? '0 : ld_idx + ADDR_W'(1);
    assign ack_ok      = pending && rd_ack && ((state_q == CMD) || (state_q == UPL));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ss_prev    <= 1'b0;
            bit_cnt    <= '0;
            len_cnt    <= '0;
            ld_idx     <= '0;
            bytes_sent <= '0;
            pending    <= 1'b0;
            nxt_valid  <= 1'b0;
            rd_req     <= 1'b0;
            rd_addr    <= '0;
            sdo        <= 1'b0;
        end else begin
            state_q <= state_d;
            ss_prev <= ss_s;
            rd_req  <= issue;

            if (state_d == IDLE)  bit_cnt <= '0;
            else if (sck_rise)    bit_cnt <= bit_cnt + 3'd1;

            if (byte_done) begin
                if (state_q == CMD)                          len_cnt <= 2'd1;
                else if ((state_q == LEN) && (len_cnt != 2'd3)) len_cnt <= len_cnt + 2'd1;
            end

            if (ss_fall)       ld_idx <= '0;
            else if (mem_load) ld_idx <= ld_idx + ADDR_W'(1);

            // ld_idx never exceeds upload_len, so this also saturates the count.
            if (byte_done && (state_q == CMD) && (state_d == UPL))
                bytes_sent <= '0;
            else if (byte_done && (state_q == UPL) && (bytes_sent < ld_idx))
                bytes_sent <= bytes_sent + ADDR_W'(1);

            if (issue) begin
                pending <= 1'b1;
                rd_addr <= START_ADDR + read_idx;
            end else if (rd_ack) begin
                pending <= 1'b0;
            end

            if (ss_fall)       nxt_valid <= 1'b0;
            else if (ack_ok)   nxt_valid <= 1'b1;
            else if (mem_load) nxt_valid <= 1'b0;

            if (state_d == IDLE) sdo <= 1'b0;
            else if (sck_fall)   sdo <= tx[7];
        end
    end

    always_ff @(posedge clk) begin
        if (sck_rise) rx <= {rx[5:0], sdi_s};
        if (ss_fall)        tx <= 8'h00;
        else if (byte_done) tx <= load_byte;
        else if (sck_fall)  tx <= {tx[6:0], 1'b0};
        if (ack_ok) nxt <= rd_data;
    end

    assign sdo_oe    = !ss_s && (state_q != IDLE);
    assign uploading = (state_q == UPL);

endmodule

// File: doc/data_upload.md
Name: data_upload

Overview:
- SPI slave transmitter that is the reverse of the ROM-download path: the ARM io controller pulls memory contents (tape/snapshot save) out of SDRAM over SPI.
- Sits beside the download helper on SPI_SS2, sharing SPI_SCK and SPI_DI, and drives SPI_DO through sdo/sdo_oe.
- Reads memory through a request/ack port that the top level muxes into the sdram address/oe path while `uploading` is high.

Parameters:
- ADDR_W, 25, memory address width (matches the sdram addr port).
- START_ADDR, 25'h0, first address streamed by an upload.
- CMD_LEN, 8'h56, command code: report upload length.
- CMD_UPLOAD, 8'h57, command code: stream memory.

Ports:
- clk  in  1  system clock (F14M domain).
- reset_n  in  1  asynchronous active-low reset.
- sck  in  1  SPI clock, asynchronous; guaranteed ≤ clk/4.
- ss  in  1  SPI select, active low.
- sdi  in  1  SPI MOSI.
- sdo  out  1  SPI MISO data.
- sdo_oe  out  1  MISO output enable; top level drives Z when 0.
- upload_len  in  ADDR_W  number of bytes to stream; stable during a frame.
- uploading  out  1  high during a CMD_UPLOAD frame.
- rd_req  out  1  one-clk memory read request pulse.
- rd_addr  out  ADDR_W  read address, held from rd_req until rd_ack.
- rd_data  in  8  read data, valid with rd_ack.
- rd_ack  in  1  one-clk read completion; latency ≤ 16 clk.
- bytes_sent  out  ADDR_W  memory bytes shifted out in the current/last upload.

Behaviour:
- Synchronisation: sck, ss and sdi each pass through 2-FF synchronisers. Edge detection runs on the synchronised sck.
- Bit timing: SPI mode 0, MSB first.
  - sdi is sampled on each sck rising edge.
  - sdo updates on each sck falling edge, within 3 clk of that edge.
- Framing: a frame is one ss-low period. Byte 0 is the command; bytes 1..n are response bytes.
- Response byte k's MSB is placed on sdo at the falling edge after byte k-1's 8th rising edge.
- sdo_oe = !ss_sync. sdo = 0 while receiving byte 0.
- FSM states:
  - IDLE: ss high; shift/bit counters cleared.
  - CMD: entered on ss fall. After the 8th rising edge, go to LEN if the byte equals CMD_LEN, UPL if CMD_UPLOAD, else DRAIN.
  - LEN: sends upload_len[23:16], [15:8], [7:0], then 0x00 for every further byte.
  - UPL: byte k (k ≥ 1) = mem[START_ADDR+k-1] while k-1 < upload_len, else 0x00.
  - DRAIN: sdo = 0 until ss rises.
  - Any state → IDLE on ss_sync rising, including mid-byte. The partial byte is discarded and bytes_sent holds its value.
- Prefetch (one-byte buffer `nxt`, flag nxt_valid):
  - On ss fall, speculatively issue rd_req at START_ADDR, provided upload_len ≠ 0. Reads have no side effects.
  - When a byte is loaded into the TX shift register in UPL, issue rd_req for the following address if still < upload_len.
  - rd_req is not reissued while a request is outstanding.
  - rd_ack arriving after leaving UPL/CMD is dropped.
  - Buffer underrun (nxt not valid at load time) sends 0xFF and sets no further state. This is a protocol violation that benches flag.
- rd_addr = START_ADDR + read index, in ADDR_W bits, wrapping modulo 2^ADDR_W.
- bytes_sent:
  - Cleared on entry to UPL.
  - Increments as each memory byte finishes shifting (8th rising edge).
  - Saturates at upload_len.
- uploading: set on entry to UPL, cleared on IDLE.
- Reset (async, any time): all state goes to IDLE. sdo = 0, sdo_oe = 0, uploading = 0, rd_req = 0, rd_addr = 0, bytes_sent = 0, nxt_valid = 0.
- After reset release with ss already low, the block stays in IDLE until ss goes high. It never joins a frame mid-way.

Decomposition:
- Package laser500_pkg: CMD_LEN/CMD_UPLOAD defaults, the state enum (IDLE, CMD, LEN, UPL, DRAIN), and the underrun fill value 8'hFF.
- Sub-module spi_in_sync: 2-FF synchroniser for sck/ss/sdi plus one-clk sck_rise and sck_fall pulses. It is reusable by the download helper.

Test Plan:
- Reset during an active UPL frame → all outputs 0 immediately. The next frame after ss high→low works normally.
- upload_len=0x012345, frame CMD_LEN plus 4 bytes → MISO returns 0x01, 0x23, 0x45, 0x00. rd_req never pulses after the initial speculative fetch.
- Memory model 0x1000+i → i[7:0], START_ADDR=0x1000, upload_len=5, frame CMD_UPLOAD plus 7 bytes at sck=clk/4, rd_ack latency 16 → MISO returns 00, 01, 02, 03, 04, 00, 00. bytes_sent=5. uploading is high only during the frame. Exactly 5 rd_req pulses.
- ss raised after 3 bits of response byte 2 in UPL → state IDLE within 3 clk, uploading=0, bytes_sent=1. A new CMD_UPLOAD frame restarts at START_ADDR.
- Unknown command 0xA5, then 3 bytes → MISO all 0x00. No rd_req beyond the speculative one. uploading stays 0.
- START_ADDR = 2^25-2, upload_len=4 → rd_addr sequence 1FFFFFE, 1FFFFFF, 0000000, 0000001 (wrap).
